// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared constants, types and double-to-pixel helpers for the n-body plotter
package nbody_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int EXP_BIAS    = 1023;
    localparam int EXP_WIDTH   = 11;
    localparam int MANT_WIDTH  = 52;
    localparam int MAX_INT_EXP = 15;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PIX_X_WIDTH = 10;
    localparam int PIX_Y_WIDTH = 9;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} plot_state_t;

    typedef struct packed {
        logic [PIX_X_WIDTH-1:0] pix_x;
        logic [PIX_Y_WIDTH-1:0] pix_y;
        logic                   vis;
        logic                   last;
    } beat_t;

    typedef struct packed {
        logic               oor;
        logic signed [16:0] val;
    } conv_t;

    // Truncate toward zero; anything with |value| >= 2^MAX_INT_EXP or Inf/NaN is out-of-range.
    function automatic conv_t dbl_to_int(input logic [DATA_WIDTH-1:0] d);
        conv_t                  r;
        logic [EXP_WIDTH-1:0]   ex;
        logic [MANT_WIDTH:0]    m;
        logic [5:0]             sh;
        logic [MAX_INT_EXP-1:0] mag;
        ex  = d[62:52];
        m   = {1'b1, d[51:0]};
        sh  = 6'(11'(EXP_BIAS + MANT_WIDTH) - ex);
        mag = MAX_INT_EXP'(m >> sh);
        r   = '0;
        if (ex == '1) begin
            r.oor = 1'b1;
        end else if (ex < EXP_WIDTH'(EXP_BIAS)) begin
            r.val = '0;
        end else if (ex >= EXP_WIDTH'(EXP_BIAS + MAX_INT_EXP)) begin
            r.oor = 1'b1;
        end else begin
            r.val = d[63] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
        end
        return r;
    endfunction

    function automatic beat_t pix_map(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y,
                                      input logic last, input int sw, input int sh);
        conv_t              cx;
        conv_t              cy;
        logic signed [17:0] px;
        logic signed [17:0] py;
        logic signed [17:0] sw18;
        logic signed [17:0] sh18;
        logic               vis;
        beat_t              b;
        cx   = dbl_to_int(x);
        cy   = dbl_to_int(y);
        sw18 = 18'(sw);
        sh18 = 18'(sh);
        px   = $signed({cx.val[16], cx.val}) + 18'(sw / 2);
        py   = 18'(sh / 2) - $signed({cy.val[16], cy.val});
        vis  = !cx.oor && !cy.oor && (px >= 18'sd0) && (px < sw18) && (py >= 18'sd0) && (py < sh18);
        b.pix_x = vis ? px[PIX_X_WIDTH-1:0] : '0;
        b.pix_y = vis ? py[PIX_Y_WIDTH-1:0] : '0;
        b.vis   = vis;
        b.last  = last;
        return b;
    endfunction

endpackage

// File: rtl/body_plotter_if.sv
// rtl/body_plotter_if.sv - pixel beat stream between plotter and framebuffer writer
interface body_plotter_if #(
    parameter int PIX_X_WIDTH = 10,
    parameter int PIX_Y_WIDTH = 9
);
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIX_X_WIDTH-1:0] pix_x;
    logic [PIX_Y_WIDTH-1:0] pix_y;
    logic                   pix_vis;
    logic                   pix_last;

    modport master (output pix_valid, pix_x, pix_y, pix_vis, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_vis, pix_last, output pix_ready);
endinterface

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - small synchronous FIFO with show-ahead head and occupancy count
module plot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/body_plotter.sv
// rtl/body_plotter.sv - walks body positions after each core step and streams screen pixels
module body_plotter
    import nbody_pkg::*;
#(
    parameter int BODIES          = 512,
    parameter int DATA_WIDTH      = nbody_pkg::DATA_WIDTH,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int RAM_LATENCY     = 2,
    parameter int SCREEN_W        = nbody_pkg::SCREEN_W,
    parameter int SCREEN_H        = nbody_pkg::SCREEN_H,
    parameter int PIX_X_WIDTH     = nbody_pkg::PIX_X_WIDTH,
    parameter int PIX_Y_WIDTH     = nbody_pkg::PIX_Y_WIDTH,
    parameter int FIFO_DEPTH      = RAM_LATENCY + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
    output logic [BODY_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_en,
    input  logic [DATA_WIDTH-1:0]      x_in,
    input  logic [DATA_WIDTH-1:0]      y_in,
    body_plotter_if.master             pix,
    output logic                       busy,
    output logic                       done,
    output logic [BODY_ADDR_WIDTH:0]   clip_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    plot_state_t                state;
    logic [BODY_ADDR_WIDTH-1:0] nb;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic                       rd_last;
    logic [RAM_LATENCY-1:0]     vpipe;
    logic [RAM_LATENCY-1:0]     lpipe;
    logic                       conv_valid;
    beat_t                      conv_beat;
    logic [CW-1:0]              outstanding;
    logic [CW-1:0]              fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    beat_t                      head;
    logic                       pop;
    logic                       credit;
    logic                       issue;
    logic                       issue_last;
    logic [BODY_ADDR_WIDTH-1:0] issue_idx;
    logic [BODY_ADDR_WIDTH-1:0] issue_n;
    logic                       drain_done;

    // Index 0 is issued on the start edge itself so the first beat lands five cycles after start.
    assign issue_idx  = (state == IDLE) ? '0 : idx;
    assign issue_n    = (state == IDLE) ? num_bodies : nb;
    assign issue_last = (issue_idx == issue_n - BODY_ADDR_WIDTH'(1));
    assign credit     = !fifo_full && (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign issue      = ((state == IDLE) && start && (num_bodies != '0)) || ((state == RUN) && credit);
    assign pop        = pix.pix_valid && pix.pix_ready;
    assign drain_done = (outstanding == '0) && (fifo_empty || ((fifo_count == CW'(1)) && pop));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            nb         <= '0;
            idx        <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
            done       <= 1'b0;
            clip_count <= '0;
        end else begin
            done    <= 1'b0;
            rd_en   <= issue;
            rd_last <= issue && issue_last;
            case (state)
                IDLE: if (start) begin
                    nb  <= num_bodies;
                    idx <= '0;
                    if (num_bodies == '0) done  <= 1'b1;
                    else                  state <= issue_last ? DRAIN : RUN;
                end
                RUN: if (issue && issue_last) state <= DRAIN;
                DRAIN: if (drain_done) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (issue) begin
                rd_addr <= issue_idx;
                idx     <= issue_idx + 1'b1;
            end
            if ((state == IDLE) && start) clip_count <= '0;
            else if (conv_valid && !conv_beat.vis && (clip_count != '1)) clip_count <= clip_count + 1'b1;
        end
    end

    // Outstanding covers the RAM delay line plus the conversion register; it drops when the beat is pushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vpipe       <= '0;
            lpipe       <= '0;
            conv_valid  <= 1'b0;
            conv_beat   <= '0;
            outstanding <= '0;
        end else begin
            vpipe[0] <= rd_en;
            lpipe[0] <= rd_last;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
            conv_valid <= vpipe[RAM_LATENCY-1];
            conv_beat  <= pix_map(x_in, y_in, lpipe[RAM_LATENCY-1], SCREEN_W, SCREEN_H);
            if (issue && !conv_valid)      outstanding <= outstanding + 1'b1;
            else if (!issue && conv_valid) outstanding <= outstanding - 1'b1;
        end
    end

    plot_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (conv_valid),
        .push_data (conv_beat),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy          = (state != IDLE);
    assign pix.pix_valid = !fifo_empty;
    assign pix.pix_x     = fifo_empty ? '0 : PIX_X_WIDTH'(head.pix_x);
    assign pix.pix_y     = fifo_empty ? '0 : PIX_Y_WIDTH'(head.pix_y);
    assign pix.pix_vis   = !fifo_empty && head.vis;
    assign pix.pix_last  = !fifo_empty && head.last;
endmodule

// File: tb/tb_body_plotter.sv
// tb/tb_body_plotter.sv - self-checking bench for body_plotter with a real-number pixel model
module tb_body_plotter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  num_bodies = '0;
    logic [8:0]  rd_addr;
    logic        rd_en;
    logic [63:0] x_in;
    logic [63:0] y_in;
    logic        busy;
    logic        done;
    logic [9:0]  clip_count;

    body_plotter_if #(.PIX_X_WIDTH(10), .PIX_Y_WIDTH(9)) pif ();

    body_plotter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_bodies (num_bodies),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .x_in       (x_in),
        .y_in       (y_in),
        .pix        (pif),
        .busy       (busy),
        .done       (done),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    logic [63:0] xmem [512];
    logic [63:0] ymem [512];
    logic [8:0]  a1;
    always @(posedge clk) begin
        a1   <= rd_addr;
        x_in <= xmem[a1];
        y_in <= ymem[a1];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit to_int(input logic [63:0] b, output int v);
        real r;
        v = 0;
        if (b[62:52] == 11'h7ff) return 1'b0;
        r = $bitstoreal(b);
        if (r >= 32768.0 || r <= -32768.0) return 1'b0;
        v = $rtoi(r);
        return 1'b1;
    endfunction

    function automatic logic [19:0] model_pix(input logic [63:0] xb, input logic [63:0] yb);
        int ix, iy, px, py;
        bit okx, oky;
        logic [9:0] qx;
        logic [8:0] qy;
        okx = to_int(xb, ix);
        oky = to_int(yb, iy);
        px  = ix + 320;
        py  = 240 - iy;
        if (!(okx && oky && px >= 0 && px < 640 && py >= 0 && py < 480)) return 20'd0;
        qx = 10'(px);
        qy = 9'(py);
        return {qx, qy, 1'b1};
    endfunction

    function automatic logic [63:0] rnd_coord(input int lim);
        int sel;
        int u;
        sel = int'($urandom_range(0, 19));
        if (sel == 0) return 64'h7ff8_0000_0000_0000;
        if (sel == 1) return $realtobits(1.0e6);
        u = int'($urandom_range(0, lim * 200));
        return $realtobits($itor(u - lim * 100) / 100.0);
    endfunction

    logic [20:0] exp_q [$];
    logic [20:0] obs_q [$];
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, first_valid_cyc = -1, last_xfer_cyc = 0;
    int n_issued = 0, n_accepted = 0, exp_addr = 0;
    bit saw_valid = 0, saw_busy = 0, prev_stall = 0;
    logic [20:0] prev_beat;
    logic [20:0] cur_beat;

    always @(negedge clk) begin
        cyc++;
        cur_beat = {pif.pix_x, pif.pix_y, pif.pix_vis, pif.pix_last};
        if (!rst) begin
            prev_stall = 0;
            n_issued   = 0;
            n_accepted = 0;
            exp_addr   = 0;
        end else begin
            if (start && !busy) begin
                start_cyc = cyc; first_valid_cyc = -1; n_issued = 0; n_accepted = 0;
                exp_addr = 0; saw_valid = 0; saw_busy = 0;
            end
            if (rd_en) begin
                chk("rd_addr_order", 64'(rd_addr), 64'(exp_addr));
                exp_addr++;
                n_issued++;
            end
            chk("credit_bound", 64'(n_issued - n_accepted > 4), 64'd0);
            if (pif.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                chk("stall_valid", 64'(pif.pix_valid), 64'd1);
                chk("stall_payload", 64'(cur_beat), 64'(prev_beat));
            end
            if (pif.pix_valid && pif.pix_ready) begin
                obs_q.push_back(cur_beat);
                n_accepted++;
                if (pif.pix_last) last_xfer_cyc = cyc;
            end
            prev_stall = pif.pix_valid && !pif.pix_ready;
            prev_beat  = cur_beat;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (pif.pix_valid) saw_valid = 1;
            if (busy) saw_busy = 1;
        end
    end

    task automatic run_frame(input int n, input int mode, input string tag);
        int k;
        int nclip;
        exp_q.delete();
        nclip = 0;
        for (int i = 0; i < n; i++) begin
            logic [19:0] b;
            b = model_pix(xmem[i], ymem[i]);
            if (!b[0]) nclip++;
            exp_q.push_back({b, (i == n - 1)});
        end
        @(posedge clk); #1;
        obs_q.delete();
        done_cnt = 0;
        num_bodies = 9'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            if (mode == 1 && k >= 50 && k < 60)  pif.pix_ready = 1'b0;
            else if (mode == 1 && k >= 60)       pif.pix_ready = ($urandom_range(0, 99) >= 30);
            else                                 pif.pix_ready = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        pif.pix_ready = 1'b1;
        chk({tag, "_timeout"}, 64'(done_cnt != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_beat_count"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        if (n > 0) chk({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
        chk({tag, "_clip_count"}, 64'(clip_count), 64'(nclip));
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 512; i++) begin xmem[i] = '0; ymem[i] = '0; end
        pif.pix_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_pix_valid", 64'(pif.pix_valid), 64'd0);
        chk("rst_pix_xy", 64'({pif.pix_x, pif.pix_y, pif.pix_vis, pif.pix_last}), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_clip", 64'(clip_count), 64'd0);
        rst = 1'b1;

        xmem[0] = $realtobits(0.0); ymem[0] = $realtobits(0.0);
        run_frame(1, 0, "origin");
        chk("origin_latency", 64'(first_valid_cyc - start_cyc), 64'd5);

        xmem[0] = $realtobits(-3.75); ymem[0] = $realtobits(100.5);
        xmem[1] = $realtobits(319.9); ymem[1] = $realtobits(-239.0);
        run_frame(2, 0, "two");

        xmem[0] = $realtobits(320.0); ymem[0] = $realtobits(0.0);
        xmem[1] = $realtobits(0.0);   ymem[1] = 64'h7ff8_0000_0000_0001;
        xmem[2] = $realtobits(1.0e6); ymem[2] = $realtobits(0.0);
        run_frame(3, 0, "clip");

        run_frame(0, 0, "empty");
        chk("empty_done_next", 64'(done_cyc), 64'(start_cyc + 1));
        chk("empty_no_valid", 64'(saw_valid), 64'd0);
        chk("empty_no_busy", 64'(saw_busy), 64'd0);

        for (int i = 0; i < 300; i++) begin xmem[i] = rnd_coord(330); ymem[i] = rnd_coord(250); end
        run_frame(300, 1, "bulk");

        @(posedge clk); #1;
        done_cnt = 0;
        num_bodies = 9'd300;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (exp_addr < 100 && k < 2000) begin @(posedge clk); #1; k++; end
        chk("abort_reach_100", 64'(exp_addr >= 100), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_rst_outputs", 64'({rd_en, pif.pix_valid, busy, done}), 64'd0);
        chk("abort_rst_clip", 64'(clip_count), 64'd0);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            xmem[i] = $realtobits($itor(i) * 10.5);
            ymem[i] = $realtobits($itor(i) * -7.25);
        end
        run_frame(5, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/body_plotter.md
Name: body_plotter

Overview:
- Downstream consumer of the n-body core's position memories.
- After the core signals a completed step, walks bodies 0..num_bodies-1 and reads x/y (IEEE-754 double) through the core's secondary position read port.
- Converts each coordinate to a screen pixel and streams one beat per body to the framebuffer writer over a valid/ready handshake.
- Tolerates arbitrary downstream backpressure without losing or reordering bodies.

Parameters:
- BODIES, 512: maximum body count.
- DATA_WIDTH, 64: coordinate word width, IEEE-754 double.
- BODY_ADDR_WIDTH, $clog2(BODIES): body index width.
- RAM_LATENCY, 2: cycles from rd_addr to valid x_in/y_in.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- PIX_X_WIDTH, 10: pix_x width.
- PIX_Y_WIDTH, 9: pix_y width.
- FIFO_DEPTH, RAM_LATENCY+2: output buffer depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse from core when step done.
- num_bodies  in  BODY_ADDR_WIDTH  bodies to plot; sampled on accepted start.
- rd_addr  out  BODY_ADDR_WIDTH  position RAM read address.
- rd_en  out  1  read issued this cycle.
- x_in  in  DATA_WIDTH  x position, RAM_LATENCY after rd_en.
- y_in  in  DATA_WIDTH  y position, RAM_LATENCY after rd_en.
- pix_valid  out  1  beat available.
- pix_ready  in  1  downstream accepts.
- pix_x  out  PIX_X_WIDTH  column.
- pix_y  out  PIX_Y_WIDTH  row.
- pix_vis  out  1  1 = on screen; 0 = clipped, downstream must not draw.
- pix_last  out  1  beat is body num_bodies-1.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when all beats accepted.
- clip_count  out  BODY_ADDR_WIDTH+1  clipped bodies in the current/last frame.

Behaviour:
- Reset while rst=0 at a clock edge:
  - state=IDLE; FIFO flushed; outstanding count=0.
  - All outputs 0: rd_addr, rd_en, pix_*, busy, done, clip_count.
  - Applies mid-frame: the frame is abandoned and no done pulse is issued.
- State IDLE:
  - start=1 latches num_bodies, clears clip_count and next-index.
  - If latched num_bodies=0: done pulses next cycle, state stays IDLE, no beats.
  - Otherwise go to RUN.
- State RUN:
  - Issue rd_en=1 with rd_addr=index when (outstanding reads + FIFO occupancy) < FIFO_DEPTH.
  - Index increments per issue.
  - The issue of index num_bodies-1 moves to DRAIN.
  - At most one read per cycle. Sustained throughput is one body per cycle when pix_ready stays high.
- State DRAIN:
  - No reads issued.
  - When outstanding=0, FIFO empty, and no handshake in flight: done=1 for one cycle, state returns to IDLE.
- start is ignored in RUN and DRAIN.
- Read pipeline: a delay line of RAM_LATENCY rd_en bits marks x_in/y_in valid. Valid data is converted in one registered stage, then pushed into the FIFO.
- Outstanding count covers in-flight reads plus the conversion stage. Credit check guarantees the FIFO never overflows.
- Double to integer (per coordinate), truncation toward zero; e = exp-1023:
  - exp=0 (zero/denormal) -> 0.
  - exp=2047 (Inf/NaN) -> out-of-range.
  - e<0 -> 0.
  - e>=15 -> out-of-range.
  - else magnitude = {1,mantissa} >> (52-e), negated if sign set.
- Pixel mapping:
  - pix_x = ix + SCREEN_W/2.
  - pix_y = SCREEN_H/2 - iy (world y up).
  - Clipped if either coordinate is out-of-range, pix_x not in [0,SCREEN_W), or pix_y not in [0,SCREEN_H).
- Clipped beats:
  - pix_vis=0 and pix_x=pix_y=0.
  - clip_count increments at FIFO push, saturating at 2^(BODY_ADDR_WIDTH+1)-1.
- Handshake:
  - A beat transfers when pix_valid && pix_ready.
  - pix_x/pix_y/pix_vis/pix_last hold stable while pix_valid && !pix_ready.
  - pix_valid never drops without a transfer.
- FIFO:
  - Simultaneous push and pop on a full FIFO is legal; the credit rule makes a full push impossible without a pop.
  - Pop on empty is impossible (pix_valid=0).
- Beats emerge in index order 0..num_bodies-1.
- Latency from start: first pix_valid at cycle 1 + RAM_LATENCY + 1 + 1 (issue, RAM, convert, FIFO output register).

Decomposition:
- Shared package nbody_pkg:
  - DATA_WIDTH, EXP_BIAS=1023, EXP_WIDTH=11, MANT_WIDTH=52, MAX_INT_EXP=15.
  - SCREEN_W/H.
  - Plotter state enum {IDLE, RUN, DRAIN}.
  - Beat struct {pix_x, pix_y, vis, last}.
- One sub-module, plot_fifo: synchronous FIFO, parameterised width/depth, push/pop/full/empty/count.
- Conversion stays as a function in the package, shared for x and y.

Test Plan:
- Single body x=0.0, y=0.0, num_bodies=1, pix_ready=1 -> one beat (320,240), vis=1, last=1; done exactly one cycle after the transfer; clip_count=0.
- Bodies x=-3.75/y=100.5 and x=319.9/y=-239.0 -> beats (317,140) vis=1, then (639,479) vis=1; last only on second.
- x=320.0, y=NaN, x=1e6 across 3 bodies -> three beats all vis=0, coords 0; clip_count=3; order preserved.
- num_bodies=0 start -> done pulses next cycle; pix_valid never asserts; busy stays 0.
- num_bodies=300, pix_ready low cycles 50-59 and randomly 30% thereafter -> exactly 300 beats, indices in order, no duplicates; rd_en stalls while credit exhausted; payload stable under stall.
- rst=0 mid-RUN at body 100, then start with num_bodies=5 -> no done for aborted frame; new frame emits 5 beats from index 0.
